// File: rtl/result_collector_if.sv
// rtl/result_collector_if.sv - capture-side and readout-side signals of the result collector
interface result_collector_if #(
    parameter int ITEM_WIDTH = 8
);
    logic                  in_valid_i;
    logic [ITEM_WIDTH-1:0] in_data_i;
    logic                  in_ready_o;
    logic                  batch_ready_o;
    logic [31:0]           batch_sum_o;
    logic                  rd_req_i;
    logic                  rd_valid_o;
    logic [ITEM_WIDTH-1:0] rd_data_o;
    logic                  rd_last_o;
    logic [15:0]           batch_cnt_o;
    logic                  overflow_o;

    modport master (
        output in_valid_i, in_data_i, rd_req_i,
        input  in_ready_o, batch_ready_o, batch_sum_o, rd_valid_o,
               rd_data_o, rd_last_o, batch_cnt_o, overflow_o
    );

    modport slave (
        input  in_valid_i, in_data_i, rd_req_i,
        output in_ready_o, batch_ready_o, batch_sum_o, rd_valid_o,
               rd_data_o, rd_last_o, batch_cnt_o, overflow_o
    );
endinterface

// File: rtl/result_collector.sv
// rtl/result_collector.sv - ping-pong batch capture of result items with per-batch sum and count
module result_collector #(
    parameter int NUM        = 1000,
    parameter int ITEM_WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    result_collector_if.slave bus
);
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    logic [ITEM_WIDTH-1:0] mem_q [2][NUM];
    logic [31:0]           sum_q [2];
    logic [1:0]            full_q, full_d;

    logic                  wr_bank_q;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [31:0]           run_sum_q, run_sum_d;
    logic                  rd_bank_q;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;

    logic                  rd_valid_q;
    logic [ITEM_WIDTH-1:0] rd_data_q;
    logic                  rd_last_q;
    logic [15:0]           batch_cnt_q;
    logic                  overflow_q;

    logic                  wr_acc, wr_done, rd_acc, rd_done;
    logic [31:0]           item_ext;

    assign item_ext = 32'(bus.in_data_i);
    assign wr_acc   = bus.in_valid_i & ~full_q[wr_bank_q];
    assign wr_done  = wr_acc & (wr_idx_q == LAST_IDX);
    assign rd_acc   = bus.rd_req_i & full_q[rd_bank_q];
    assign rd_done  = rd_acc & (rd_idx_q == LAST_IDX);

    // A completing write and a draining read never hit the same bank, so both updates apply.
    always_comb begin
        full_d    = full_q;
        wr_idx_d  = wr_idx_q;
        run_sum_d = run_sum_q;
        rd_idx_d  = rd_idx_q;
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_idx_d          = '0;
            run_sum_d         = '0;
        end else if (wr_acc) begin
            wr_idx_d  = wr_idx_q + 1'b1;
            run_sum_d = run_sum_q + item_ext;
        end
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
            rd_idx_d          = '0;
        end else if (rd_acc) begin
            rd_idx_d = rd_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_bank_q][wr_idx_q] <= bus.in_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_q      <= '0;
            sum_q[0]    <= '0;
            sum_q[1]    <= '0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            run_sum_q   <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_last_q   <= 1'b0;
            batch_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_idx_q  <= wr_idx_d;
            run_sum_q <= run_sum_d;
            rd_idx_q  <= rd_idx_d;
            if (wr_done) begin
                sum_q[wr_bank_q] <= run_sum_q + item_ext;
                wr_bank_q        <= ~wr_bank_q;
                batch_cnt_q      <= batch_cnt_q + 16'd1;
            end
            if (bus.in_valid_i & full_q[wr_bank_q]) begin
                overflow_q <= 1'b1;
            end
            if (rd_done) begin
                rd_bank_q <= ~rd_bank_q;
            end
            rd_valid_q <= rd_acc;
            rd_last_q  <= rd_done;
            if (rd_acc) begin
                rd_data_q <= mem_q[rd_bank_q][rd_idx_q];
            end
        end
    end

    assign bus.in_ready_o    = ~full_q[wr_bank_q];
    assign bus.batch_ready_o = full_q[rd_bank_q];
    assign bus.batch_sum_o   = sum_q[rd_bank_q];
    assign bus.rd_valid_o    = rd_valid_q;
    assign bus.rd_data_o     = rd_data_q;
    assign bus.rd_last_o     = rd_last_q;
    assign bus.batch_cnt_o   = batch_cnt_q;
    assign bus.overflow_o    = overflow_q;
endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - directed and random checks of result_collector against a batch-queue model
module tb_result_collector;
    localparam int NUM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    result_collector_if #(.ITEM_WIDTH(8)) bus ();

    result_collector #(.NUM(NUM), .ITEM_WIDTH(8)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    // Model: completed undrained items in arrival order plus the batch still being built.
    logic [7:0]  m_items[$];
    logic [7:0]  m_part[$];
    int          m_rd_ptr;
    logic        m_rv, m_rl, m_ovf;
    logic [7:0]  m_rd;
    logic [15:0] m_cnt;
    logic [31:0] sums_seen[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] front_sum();
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < NUM; i++) s += 32'(m_items[i]);
        return s;
    endfunction

    task automatic model_reset();
        m_items.delete();
        m_part.delete();
        m_rd_ptr = 0;
        m_rv = 0; m_rl = 0; m_ovf = 0; m_rd = '0; m_cnt = '0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},    bus.in_ready_o,    1);
        chk({tag, "_batch_ready"}, bus.batch_ready_o, 0);
        chk({tag, "_batch_sum"},   bus.batch_sum_o,   0);
        chk({tag, "_rd_valid"},    bus.rd_valid_o,    0);
        chk({tag, "_rd_data"},     bus.rd_data_o,     0);
        chk({tag, "_rd_last"},     bus.rd_last_o,     0);
        chk({tag, "_batch_cnt"},   bus.batch_cnt_o,   0);
        chk({tag, "_overflow"},    bus.overflow_o,    0);
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        bit rd_acc, wr_ok;
        bus.in_valid_i = v;
        bus.in_data_i  = d;
        bus.rd_req_i   = r;
        @(posedge clk);
        rd_acc = r && (m_items.size() >= NUM);
        wr_ok  = (m_items.size() < 2 * NUM);
        m_rv = rd_acc;
        m_rl = rd_acc && (m_rd_ptr == NUM - 1);
        if (rd_acc) m_rd = m_items[m_rd_ptr];
        if (v && wr_ok) begin
            m_part.push_back(d);
            if (m_part.size() == NUM) begin
                foreach (m_part[i]) m_items.push_back(m_part[i]);
                m_part.delete();
                m_cnt++;
            end
        end else if (v) begin
            m_ovf = 1;
        end
        if (rd_acc) begin
            if (m_rd_ptr == NUM - 1) begin
                repeat (NUM) void'(m_items.pop_front());
                m_rd_ptr = 0;
            end else begin
                m_rd_ptr++;
            end
        end
        #1;
        chk("in_ready",    bus.in_ready_o,    32'(m_items.size() < 2 * NUM));
        chk("batch_ready", bus.batch_ready_o, 32'(m_items.size() >= NUM));
        if (m_items.size() >= NUM) chk("batch_sum", bus.batch_sum_o, front_sum());
        chk("rd_valid",    bus.rd_valid_o,    32'(m_rv));
        if (m_rv) begin
            chk("rd_data", bus.rd_data_o, 32'(m_rd));
            chk("rd_last", bus.rd_last_o, 32'(m_rl));
        end
        chk("batch_cnt",   bus.batch_cnt_o,   32'(m_cnt));
        chk("overflow",    bus.overflow_o,    32'(m_ovf));
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        bus.in_valid_i = 0;
        bus.rd_req_i   = 0;
        rst = 1;
        #1;
        check_reset_values(tag);
        model_reset();
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    initial begin
        int pushed;
        bus.in_valid_i = 0;
        bus.in_data_i  = '0;
        bus.rd_req_i   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check_reset_values("por");

        // Empty read
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
        chk("empty_rd_valid", bus.rd_valid_o, 0);

        // Single batch
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 0);
        chk("sb_ready", bus.batch_ready_o, 1);
        chk("sb_sum",   bus.batch_sum_o,   10);
        chk("sb_cnt",   bus.batch_cnt_o,   1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 8'h00, 1);
            chk("sb_rd_data", bus.rd_data_o, i);
            chk("sb_rd_last", bus.rd_last_o, (i == 4) ? 1 : 0);
        end
        chk("sb_drained", bus.batch_ready_o, 0);

        // Fill both banks, then overflow
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0);
        chk("fill_in_ready", bus.in_ready_o, 0);
        step(1, 8'h99, 0);
        chk("fill_overflow", bus.overflow_o, 1);
        for (int i = 1; i <= 8; i++) begin
            step(0, 8'h00, 1);
            chk("fill_rd_data", bus.rd_data_o, i);
        end
        chk("fill_empty", bus.batch_ready_o, 0);

        // Concurrent stream with immediate draining
        pulse_reset("rst1");
        pushed = 0;
        sums_seen.delete();
        for (int n = 0; n < 24; n++) begin
            bit r;
            r = (m_items.size() >= NUM);
            if (r && m_rd_ptr == 0) sums_seen.push_back(bus.batch_sum_o);
            if (pushed < 12) chk("cc_in_ready", bus.in_ready_o, 1);
            step(pushed < 12, 8'(8'h10 + pushed), r);
            if (pushed < 12) pushed++;
        end
        chk("cc_overflow", bus.overflow_o, 0);
        chk("cc_cnt", bus.batch_cnt_o, 3);
        chk("cc_nsums", sums_seen.size(), 3);
        if (sums_seen.size() == 3) begin
            chk("cc_sum0", sums_seen[0], 32'h46);
            chk("cc_sum1", sums_seen[1], 32'h56);
            chk("cc_sum2", sums_seen[2], 32'h66);
        end

        // Reset in the middle of a batch
        step(1, 8'h21, 0);
        step(1, 8'h22, 0);
        pulse_reset("rst2");
        for (int i = 5; i <= 8; i++) step(1, 8'(i), 0);
        chk("rm_sum", bus.batch_sum_o, 26);
        chk("rm_cnt", bus.batch_cnt_o, 1);

        // Sum wider than an item
        pulse_reset("rst3");
        for (int i = 0; i < 4; i++) step(1, 8'hFF, 0);
        chk("sw_sum", bus.batch_sum_o, 32'h3FC);

        // Random traffic
        pulse_reset("rst4");
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/result_collector.md
# result_collector

Downstream capture stage for the DUT result stream. Samples `res_o` items, packs them into batches of NUM items in a two-bank (ping-pong) buffer, and exposes each completed batch to the testbench for readout. Each batch carries a checksum and a batch count. The host drains one bank while the other fills, so the stimulus side never stalls while a drain keeps pace.

## Interface
- NUM, 1000, items per batch; must be ≥ 2.
- ITEM_WIDTH, 8, bits per result item.
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  result item present this cycle.
- in_data_i  in  ITEM_WIDTH  result item (DUT `res_o`).
- in_ready_o  out  1  write bank has room; combinational from the bank state.
- batch_ready_o  out  1  the read bank holds a complete, undrained batch.
- batch_sum_o  out  32  sum of the items in the read bank; valid while batch_ready_o=1.
- rd_req_i  in  1  request the next item from the read bank.
- rd_valid_o  out  1  rd_data_o valid (registered).
- rd_data_o  out  ITEM_WIDTH  item read out.
- rd_last_o  out  1  qualifies the final item of a batch, together with rd_valid_o.
- batch_cnt_o  out  16  completed batches since reset; wraps 0xFFFF→0.
- overflow_o  out  1  sticky: an item was presented while in_ready_o=0.

## Operation
- Storage: two banks of NUM×ITEM_WIDTH. Each bank has a state bit: EMPTY=0, FULL=1. Each bank also has a 32-bit sum register.
- Write side: wr_bank (1 bit), wr_idx (0..NUM-1), run_sum (32 bits).
  - in_ready_o = ~full[wr_bank].
  - Accept = in_valid_i & in_ready_o. On accept: mem[wr_bank][wr_idx] ← in_data_i and run_sum += zero-extended in_data_i.
  - On accept with wr_idx=NUM-1:
    - full[wr_bank] ← 1.
    - sum[wr_bank] ← run_sum + in_data_i.
    - run_sum ← 0, wr_idx ← 0.
    - wr_bank toggles.
    - batch_cnt_o increments.
  - Otherwise on accept, wr_idx increments.
- Dropped item: in_valid_i=1 with in_ready_o=0 is dropped. overflow_o ← 1 and stays 1 until reset. No state other than overflow_o changes.
- Read side: rd_bank (1 bit), rd_idx (0..NUM-1).
  - batch_ready_o = full[rd_bank]; batch_sum_o = sum[rd_bank].
  - Read accept = rd_req_i & batch_ready_o. Next cycle: rd_valid_o=1 and rd_data_o = mem[rd_bank][rd_idx]. rd_last_o=1 if rd_idx was NUM-1.
  - On a read accept with rd_idx=NUM-1: full[rd_bank] ← 0, rd_idx ← 0, rd_bank toggles. Otherwise rd_idx increments.
  - rd_req_i while batch_ready_o=0 is ignored: rd_valid_o=0 next cycle, no state change.
- Arithmetic: run_sum and the bank sums wrap modulo 2^32. Indices compare against NUM-1 exactly; they never exceed it.

## Timing
- Reset values: in_ready_o=1, batch_ready_o=0, batch_sum_o=0, rd_valid_o=0, rd_data_o=0, rd_last_o=0, batch_cnt_o=0, overflow_o=0. Internally: wr_bank=rd_bank=0, both indices 0, both banks EMPTY, sums 0.
- Reset asserted mid-batch discards both banks and all partial data immediately (asynchronous). Memory contents are don't-care after reset.
- Batch completion latency: batch_ready_o rises in the cycle after the accept of item NUM-1, when that bank is the read bank.
- Read latency: 1 cycle from read accept to rd_valid_o. rd_req_i may be held high for back-to-back reads at 1 item per cycle.
- Bank release: the bank becomes writable in the cycle after its last read accept. If the writer was stalled on it, in_ready_o rises that cycle.
- Simultaneous events:
  - Write completion and read drain in the same cycle always target different banks; both take effect.
  - When both banks are FULL, the read bank is the older batch (FIFO order preserved).
- Throughput: with continuous draining, in_ready_o never drops.

## Test plan
All scenarios use NUM=4.
- Single batch: push 1,2,3,4 on consecutive cycles.
  - Required: batch_ready_o=1 the cycle after item 4, batch_sum_o=10, batch_cnt_o=1.
  - Then assert rd_req_i for 4 cycles. Required: rd_data_o=1,2,3,4, rd_last_o only with 4, batch_ready_o=0 after the 4th read accept.
- Fill both banks: push 8 items without reading.
  - Required: in_ready_o=0 after item 8.
  - A 9th item sets overflow_o=1 and is not stored.
  - Draining then returns items 1..4 followed by items 5..8.
- Concurrent operation: stream 12 items continuously (values 0x10..0x1B) while draining each batch as soon as batch_ready_o=1.
  - Required: in_ready_o never drops, overflow_o stays 0, batch_cnt_o=3.
  - Required sums: 0x46, 0x56, 0x66.
- Empty read: rd_req_i=1 for 3 cycles after reset. Required: rd_valid_o stays 0 and no index moves.
- Reset mid-operation: push 2 items, pulse reset_i between clock edges.
  - Required: all outputs return to reset values at once.
  - A following batch 5,6,7,8 yields batch_sum_o=26 and batch_cnt_o=1.
- Sum width: push four items of 0xFF. Required: batch_sum_o=0x3FC, with no truncation to ITEM_WIDTH.
